// File: rtl/hub75_bcm_driver_if.sv
// Host-side bus of the HUB75 BCM driver: pixel writes into the back buffer,
// the swap request/status pair, the global brightness and the frame tick.
//   master: host (drives writes, swap_req, brightness)
//   slave : driver (drives swap_pending, frame_done)
interface hub75_bcm_driver_if #(
  parameter int unsigned AW = 13,
  parameter int unsigned DW = 12
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          swap_req;
  logic [7:0]    brightness;
  logic          swap_pending;
  logic          frame_done;

  modport master (
    output wr_en, wr_addr, wr_data, swap_req, brightness,
    input  swap_pending, frame_done
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, swap_req, brightness,
    output swap_pending, frame_done
  );
endinterface

// File: rtl/hub75_bcm_driver.sv
// HUB75 panel driver with a double-buffered framebuffer and BCM colour depth.
// Scans the front bank row pair by row pair, bit plane by bit plane
// (SHIFT -> LATCH -> DISPLAY), scaling each plane's on-time by brightness.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   host (slave)       pixel writes, swap_req/swap_pending, brightness, frame_done
//   sclk, lat, oe      panel shift clock, latch, output enable (1 blanks)
//   r0,g0,b0,r1,g1,b1  upper-half / lower-half colour bits
//   o_row_select       row-pair address
// All panel outputs are registered, so they trail the internal scan state by
// one cycle; relative timing between them is preserved.
module hub75_bcm_driver #(
  parameter int unsigned WIDTH       = 96,
  parameter int unsigned HEIGHT      = 48,
  parameter int unsigned BPC         = 4,
  parameter int unsigned BASE_CYCLES = 8,
  localparam int unsigned AW = $clog2(WIDTH * HEIGHT),
  localparam int unsigned RW = (HEIGHT > 2) ? $clog2(HEIGHT / 2) : 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  hub75_bcm_driver_if.slave host,
  output logic              sclk,
  output logic              lat,
  output logic              oe,
  output logic              r0,
  output logic              g0,
  output logic              b0,
  output logic              r1,
  output logic              g1,
  output logic              b1,
  output logic [RW-1:0]     o_row_select
);

  localparam int unsigned HALF = HEIGHT / 2;
  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned DW   = 3 * BPC;
  localparam int unsigned MW   = $clog2(2 * NPIX);
  localparam int unsigned XW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned BW   = (BPC > 1) ? $clog2(BPC) : 1;
  localparam int unsigned CW   = $clog2(BASE_CYCLES << (BPC - 1)) + 1;
  localparam int unsigned PW   = CW + 9;

  typedef enum logic [1:0] {
    ST_SHIFT   = 2'd0,
    ST_LATCH   = 2'd1,
    ST_DISPLAY = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d;
  logic [1:0]      ph_q, ph_d;
  logic [RW-1:0]   row_q, row_d;
  logic [BW-1:0]   pl_q, pl_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   on_q;
  logic            front_q;
  logic            pend_q;
  logic            fd_q;
  logic [DW-1:0]   upper_q;
  logic [DW-1:0]   rd_q;

  logic [CW-1:0]   t_len;
  logic [PW-1:0]   on_prod;
  logic            last_plane, last_row, disp_last, frame_end_c;
  logic [AW-1:0]   rd_pix;
  logic [MW-1:0]   rd_idx, wr_idx;

  logic            sclk_d, lat_d, oe_d;
  logic [5:0]      rgb_d;
  logic [RW-1:0]   row_sel_d;

  logic [BPC-1:0]  up_r, up_g, up_b, lo_r, lo_g, lo_b;

  logic [DW-1:0]   mem [2*NPIX];

  // Plane timing and on-time; the product keeps its full width before >>8
  assign t_len       = CW'(BASE_CYCLES) << pl_q;
  assign on_prod     = PW'(t_len) * (PW'(host.brightness) + PW'(1));
  assign last_plane  = (pl_q == BW'(BPC - 1));
  assign last_row    = (row_q == RW'(HALF - 1));
  assign disp_last   = (cnt_q == t_len - CW'(1));
  assign frame_end_c = (state_q == ST_DISPLAY) && disp_last && last_plane && last_row;

  // Phase 0 reads the upper-half pixel, phase 1 the lower-half pixel
  assign rd_pix = (ph_q[0] ? (AW'(row_q) + AW'(HALF)) : AW'(row_q)) * AW'(WIDTH) + AW'(x_q);
  assign rd_idx = front_q ? (MW'(rd_pix) + MW'(NPIX)) : MW'(rd_pix);
  assign wr_idx = front_q ? MW'(host.wr_addr) : (MW'(host.wr_addr) + MW'(NPIX));

  assign {up_r, up_g, up_b} = upper_q;
  assign {lo_r, lo_g, lo_b} = rd_q;

  assign host.swap_pending = pend_q;
  assign host.frame_done   = fd_q;

  // Framebuffer: host writes the back bank, scan reads the front bank
  always_ff @(posedge i_clk) begin
    if (host.wr_en && (32'(host.wr_addr) < NPIX)) begin
      mem[wr_idx] <= host.wr_data;
    end
    rd_q <= mem[rd_idx];
  end

  // Scan state register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_SHIFT;
      x_q     <= '0;
      ph_q    <= '0;
      row_q   <= '0;
      pl_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      ph_q    <= ph_d;
      row_q   <= row_d;
      pl_q    <= pl_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next scan position
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    ph_d    = ph_q;
    row_d   = row_q;
    pl_d    = pl_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_SHIFT: begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd3) begin
          if (x_q == XW'(WIDTH - 1)) begin
            x_d     = '0;
            state_d = ST_LATCH;
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      ST_LATCH: begin
        cnt_d   = '0;
        state_d = ST_DISPLAY;
      end
      ST_DISPLAY: begin
        cnt_d = cnt_q + CW'(1);
        if (disp_last) begin
          cnt_d   = '0;
          state_d = ST_SHIFT;
          if (last_plane) begin
            pl_d  = '0;
            row_d = last_row ? '0 : (row_q + RW'(1));
          end else begin
            pl_d = pl_q + BW'(1);
          end
        end
      end
      default: state_d = ST_SHIFT;
    endcase
  end

  // Panel output decode (next values of the output registers)
  always_comb begin
    sclk_d    = 1'b0;
    lat_d     = 1'b0;
    oe_d      = 1'b1;
    rgb_d     = {r0, g0, b0, r1, g1, b1};
    row_sel_d = o_row_select;
    case (state_q)
      ST_SHIFT: begin
        sclk_d = (ph_q == 2'd3);
        if (ph_q == 2'd2) begin
          rgb_d = {up_r[pl_q], up_g[pl_q], up_b[pl_q], lo_r[pl_q], lo_g[pl_q], lo_b[pl_q]};
        end
      end
      ST_LATCH: begin
        lat_d     = 1'b1;
        row_sel_d = row_q;
      end
      ST_DISPLAY: oe_d = !(cnt_q < on_q);
      default: ;
    endcase
  end

  // Pixel capture, on-time sample, and swap handshake
  always_ff @(posedge i_clk) begin
    if ((state_q == ST_SHIFT) && (ph_q == 2'd1)) begin
      upper_q <= rd_q;
    end
    if (i_rst) begin
      on_q    <= '0;
      front_q <= 1'b0;
      pend_q  <= 1'b0;
    end else begin
      if (state_q == ST_LATCH) begin
        on_q <= CW'(on_prod >> 8);
      end
      if (frame_end_c) begin
        if (pend_q || host.swap_req) begin
          front_q <= ~front_q;
        end
        pend_q <= 1'b0;
      end else if (host.swap_req) begin
        pend_q <= 1'b1;
      end
    end
  end

  // Output registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sclk         <= 1'b0;
      lat          <= 1'b0;
      oe           <= 1'b1;
      {r0, g0, b0, r1, g1, b1} <= '0;
      o_row_select <= '0;
      fd_q         <= 1'b0;
    end else begin
      sclk         <= sclk_d;
      lat          <= lat_d;
      oe           <= oe_d;
      {r0, g0, b0, r1, g1, b1} <= rgb_d;
      o_row_select <= row_sel_d;
      fd_q         <= frame_end_c;
    end
  end

endmodule
